// File: rtl/weight_buf_pkg.sv
// Shared defaults, slice-to-element address helper and bank state encoding
// for the ping-pong weight buffer.
package weight_buf_pkg;

    localparam int DATA_WIDTH_DEFAULT      = 16;
    localparam int KERNEL_SIZE_MAX_DEFAULT = 3;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    function automatic int unsigned elem_addr(input int unsigned slice,
                                              input int unsigned kk,
                                              input int unsigned k);
        return slice * kk + k;
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// One weight bank: a full-slice write port and a multi-lane registered read
// port that returns zero for lanes falling past the end of the bank.
module weight_bank_ram
    import weight_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int KK         = 9,
    parameter int DEPTH      = 576,
    parameter int READ_LANES = 4,
    parameter int SLICE_AW   = 6,
    parameter int ELEM_AW    = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [SLICE_AW-1:0]              wr_addr,
    input  logic [KK*DATA_WIDTH-1:0]         wr_data,
    input  logic                             re,
    input  logic [ELEM_AW-1:0]               rd_addr,
    output logic [READ_LANES*DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left without reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < KK; k++) begin
                mem[ELEM_AW'(elem_addr(32'(wr_addr), KK, k))] <=
                    wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (re) begin
            for (int j = 0; j < READ_LANES; j++) begin
                if (32'(rd_addr) + 32'(j) < 32'(DEPTH)) begin
                    rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= mem[ELEM_AW'(32'(rd_addr) + 32'(j))];
                end else begin
                    rd_data[j*DATA_WIDTH +: DATA_WIDTH] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/weight_buf_pingpong.sv
// Double-buffered weight store: loader fills one bank while the PE array reads
// the other. Define WEIGHT_BUF_BYPASS_RD_EN for a second read output stage (latency 2).
module weight_buf_pingpong
    import weight_buf_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int KERNEL_SIZE_MAX = KERNEL_SIZE_MAX_DEFAULT,
    parameter int SLICES          = 64,
    parameter int READ_LANES      = 4,
    localparam int KK             = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX,
    localparam int DEPTH          = SLICES * KK,
    localparam int SLICE_AW       = $clog2(SLICES),
    localparam int ELEM_AW        = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [SLICE_AW-1:0]              wr_addr,
    input  logic [KK*DATA_WIDTH-1:0]         wr_data,
    input  logic                             wr_last,
    output logic                             rd_bank_ready,
    input  logic                             rd_en,
    input  logic [ELEM_AW-1:0]               rd_addr,
    output logic [READ_LANES*DATA_WIDTH-1:0] rd_data,
    output logic                             rd_valid,
    input  logic                             rd_release,
    output logic                             err
);

    localparam int RDW = READ_LANES * DATA_WIDTH;
    localparam logic [SLICE_AW:0] SLICES_W = (SLICE_AW + 1)'(SLICES);

    logic              wb;
    logic              rb;
    bank_state_t       bank_state [2];
    logic [1:0]        full;
    logic              wr_fire;
    logic              wr_addr_ok;
    logic              wr_commit;
    logic              rd_fire;
    logic              rel_fire;
    logic              rd_valid1;
    logic              rd_sel;
    logic [RDW-1:0]    bank_q [2];
    logic [RDW-1:0]    stage1;

    assign full[0]       = (bank_state[0] == BANK_FULL);
    assign full[1]       = (bank_state[1] == BANK_FULL);
    assign wr_ready      = !rst && !full[wb];
    assign rd_bank_ready = full[rb];
    assign wr_fire       = wr_valid && wr_ready;
    assign wr_addr_ok    = {1'b0, wr_addr} < SLICES_W;
    assign wr_commit     = wr_fire && wr_addr_ok;
    assign rd_fire       = rd_en && full[rb];
    assign rel_fire      = rd_release && full[rb];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        weight_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .KK         (KK),
            .DEPTH      (DEPTH),
            .READ_LANES (READ_LANES),
            .SLICE_AW   (SLICE_AW),
            .ELEM_AW    (ELEM_AW)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .we      (wr_commit && (wb == 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .re      (rd_fire && (rb == 1'(b))),
            .rd_addr (rd_addr),
            .rd_data (bank_q[b])
        );
    end

    // A read and a release in the same cycle: the read is captured from the
    // old rb before the pointer moves, so rd_sel remembers which bank answered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb            <= 1'b0;
            rb            <= 1'b0;
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            rd_valid1     <= 1'b0;
            rd_sel        <= 1'b0;
            err           <= 1'b0;
        end else begin
            rd_valid1 <= rd_fire;
            if (rd_fire) begin
                rd_sel <= rb;
            end
            if (wr_fire && !wr_addr_ok) begin
                err <= 1'b1;
            end
            if (wr_commit && wr_last) begin
                bank_state[wb] <= BANK_FULL;
                wb             <= !wb;
            end
            if (rel_fire) begin
                bank_state[rb] <= BANK_EMPTY;
                rb             <= !rb;
            end
            if ((rd_en || rd_release) && !full[rb]) begin
                err <= 1'b1;
            end
        end
    end

    assign stage1 = bank_q[rd_sel];

`ifdef WEIGHT_BUF_BYPASS_RD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_valid1;
            if (rd_valid1) begin
                rd_data <= stage1;
            end
        end
    end
`else
    assign rd_data  = stage1;
    assign rd_valid = rd_valid1;
`endif

endmodule

// File: tb/tb_weight_buf_pingpong.sv
// Directed self-checking bench for weight_buf_pingpong; expected lane values
// are hand-computed hex constants. Works for both read-latency builds.
module tb_weight_buf_pingpong;

`ifdef WEIGHT_BUF_BYPASS_RD_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [5:0]   wr_addr;
    logic [143:0] wr_data;
    logic         wr_last;
    logic         rd_bank_ready;
    logic         rd_en;
    logic [9:0]   rd_addr;
    logic [63:0]  rd_data;
    logic         rd_valid;
    logic         rd_release;
    logic         err;

    int checks = 0;
    int errors = 0;

    weight_buf_pingpong dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .rd_bank_ready (rd_bank_ready),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_release    (rd_release),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Writes slices first..first+count-1 with element value base+element address.
    task automatic applyStimulus(input int first, input int count, input int base, input bit last);
        for (int s = first; s < first + count; s++) begin
            checkOutput("wr_ready_fill", 64'(wr_ready), 64'd1);
            wr_valid = 1'b1;
            wr_addr  = 6'(s);
            for (int k = 0; k < 9; k++) begin
                wr_data[k*16 +: 16] = 16'(base + s * 9 + k);
            end
            wr_last = last && (s == first + count - 1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Issues n (1 or 2) back-to-back reads; optional release with the first.
    task automatic readSeq(input int n, input int a0, input logic [63:0] e0,
                           input int a1, input logic [63:0] e1, input bit rel, input string tag);
        int idx;
        for (int c = 0; c < n + LAT; c++) begin
            rd_en      = (c < n);
            rd_addr    = (c == 0) ? 10'(a0) : 10'(a1);
            rd_release = rel && (c == 0);
            @(negedge clk);
            rd_release = 1'b0;
            idx = c + 1 - LAT;
            if (idx >= 0 && idx < n) begin
                checkOutput({tag, "_valid"}, 64'(rd_valid), 64'd1);
                checkOutput({tag, "_data"}, rd_data, (idx == 0) ? e0 : e1);
            end
        end
        rd_en = 1'b0;
        checkOutput({tag, "_valid_drop"}, 64'(rd_valid), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_last    = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_release = 1'b0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("wr_ready_in_reset", 64'(wr_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("rst_bank_ready", 64'(rd_bank_ready), 64'd0);
        checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_rd_data", rd_data, 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);

        // Read and release with nothing loaded.
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("empty_rd_err", 64'(err), 64'd1);
        repeat (LAT) @(negedge clk);
        checkOutput("empty_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("empty_rd_data", rd_data, 64'd0);
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
        checkOutput("empty_rel_err", 64'(err), 64'd1);
        checkOutput("empty_rel_bank_ready", 64'(rd_bank_ready), 64'd0);
        checkOutput("empty_rel_wr_ready", 64'(wr_ready), 64'd1);
        applyReset();
        checkOutput("err_cleared", 64'(err), 64'd0);

        // Bank 0 holds element value = address.
        applyStimulus(0, 64, 0, 1'b1);
        checkOutput("b0_full_bank_ready", 64'(rd_bank_ready), 64'd1);
        checkOutput("b0_full_wr_ready", 64'(wr_ready), 64'd1);
        readSeq(1, 10, 64'h000D_000C_000B_000A, 0, 64'd0, 1'b0, "rd10");
        readSeq(1, 574, 64'h0000_0000_023F_023E, 0, 64'd0, 1'b0, "rd574");
        readSeq(2, 20, 64'h0017_0016_0015_0014, 40, 64'h002B_002A_0029_0028, 1'b0, "burst");

        // Bank 1 gets 1000+address, with a bank 0 read in the middle.
        applyStimulus(0, 32, 1000, 1'b0);
        readSeq(1, 100, 64'h0067_0066_0065_0064, 0, 64'd0, 1'b0, "rd100_midfill");
        applyStimulus(32, 32, 1000, 1'b1);
        checkOutput("both_full_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("both_full_bank_ready", 64'(rd_bank_ready), 64'd1);

        // Read with release: old bank answers, then rb moves to bank 1.
        readSeq(1, 0, 64'h0003_0002_0001_0000, 0, 64'd0, 1'b1, "rd_rel");
        checkOutput("post_rel_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("post_rel_bank_ready", 64'(rd_bank_ready), 64'd1);
        readSeq(1, 0, 64'h03EB_03EA_03E9_03E8, 0, 64'd0, 1'b0, "b1_rd0");
        readSeq(1, 572, 64'h0627_0626_0625_0624, 0, 64'd0, 1'b0, "b1_rd572");
        checkOutput("no_err", 64'(err), 64'd0);

        // Reset in the middle of a layer.
        applyStimulus(0, 20, 0, 1'b0);
        applyReset();
        checkOutput("midrst_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("midrst_bank_ready", 64'(rd_bank_ready), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        applyStimulus(0, 64, 2000, 1'b1);
        checkOutput("refill_bank_ready", 64'(rd_bank_ready), 64'd1);
        readSeq(1, 300, 64'h08FF_08FE_08FD_08FC, 0, 64'd0, 1'b0, "refill_rd300");

        // Release, then a read of the now-empty bank must hold rd_data.
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
        checkOutput("rel_bank_ready", 64'(rd_bank_ready), 64'd0);
        checkOutput("rel_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("rel_err", 64'(err), 64'd0);
        rd_en   = 1'b1;
        rd_addr = 10'd5;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (LAT) @(negedge clk);
        checkOutput("hold_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("hold_rd_data", rd_data, 64'h08FF_08FE_08FD_08FC);
        checkOutput("hold_err", 64'(err), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_buf_pingpong.md
Name: weight_buf_pingpong

Overview:
- Parametrised, double-buffered (ping-pong) float16 weight store for the conv datapath.
- Successor to the single-bank weight RAM. Adds generic width/depth/kernel size, two banks so the next layer's weights load while the current layer's are consumed, valid/ready write handshake, multi-lane registered read with valid, and bank hand-over control.
- Sits between the weight loader (DMA side) and the PE-array weight fetch.

Parameters:
- DATA_WIDTH, 16, bits per weight element (float16 by default; block never interprets the value).
- KERNEL_SIZE_MAX, 3, kernel edge; one write slice = KERNEL_SIZE_MAX*KERNEL_SIZE_MAX elements (KK).
- SLICES, 64, slices per bank; element depth per bank DEPTH = SLICES*KK.
- READ_LANES, 4, consecutive elements returned per read.
- Localparams: KK, DEPTH, SLICE_AW = $clog2(SLICES), ELEM_AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  write slice offered.
- wr_ready  out  1  write bank can accept a slice.
- wr_addr  in  SLICE_AW  slice index in the write bank.
- wr_data  in  KK*DATA_WIDTH  slice; element k at bits [k*DATA_WIDTH +: DATA_WIDTH], stored at element address wr_addr*KK+k.
- wr_last  in  1  qualifies the final slice of a layer; marks the write bank full.
- rd_bank_ready  out  1  read bank holds a complete layer.
- rd_en  in  1  read request.
- rd_addr  in  ELEM_AW  first element index.
- rd_data  out  READ_LANES*DATA_WIDTH  lane j = element rd_addr+j.
- rd_valid  out  1  rd_data valid.
- rd_release  in  1  consumer finished with read bank.
- err  out  1  sticky protocol error flag.

Behaviour:
- State: wb (write bank pointer), rb (read bank pointer), full[1:0].
- Reset: wb=0, rb=0, full=0, rd_valid=0, rd_data=0, err=0.
  - Wr_ready is 0 during the reset cycle.
  - Storage contents are not cleared; bench must not rely on them.
  - Reset mid-layer discards the partial layer.
- wr_ready = !full[wb] (combinational from registered state).
- Write: wr_valid && wr_ready writes all KK elements of bank wb in one cycle.
  - wr_addr >= SLICES: write dropped, err set.
  - If wr_last is also high: full[wb] <= 1 and wb toggles on the same edge.
- rd_bank_ready = full[rb].
- Read: rd_en && full[rb] returns the data on the next edge with rd_valid=1 (latency 1).
  - rd_data and rd_valid are registered.
  - Back-to-back reads give one result per cycle.
- Lanes with rd_addr+j >= DEPTH return 0 (edge zero padding); this is not an error.
- rd_en with !full[rb]: rd_valid=0, rd_data holds its previous value, err set.
- Release: rd_release && full[rb] sets full[rb] <= 0 and toggles rb.
  - rd_release with !full[rb]: ignored, err set.
- Same-cycle events:
  - rd_en + rd_release: the read completes from the old rb, then release.
  - Write completion on wb + release on rb: both take effect; they are always different banks when both banks are in use.
  - If wb==rb and !full, the write proceeds and the release is the error case.
- Both banks full: wr_ready=0; loader stalls until a release.
- err clears only on rst.

Optional Feature:
- Macro WEIGHT_BUF_BYPASS_RD_EN.
- Defined: a read of the bank completed in the same cycle is not needed, but a read whose rd_addr element was written in the same cycle (same bank, while full[rb]) cannot occur. Instead the macro adds a second read output stage: rd_data is registered twice (latency 2, rd_valid delayed to match) for timing closure on large READ_LANES.
- Undefined: latency 1 as above.
- Verification runs both builds.

Decomposition:
- Package weight_buf_pkg: DATA_WIDTH default, KERNEL_SIZE_MAX default, a function computing element address from slice index, and the bank-state encoding.
- Sub-module weight_bank_ram: one bank. It takes one KK-wide write port and one READ_LANES-wide registered read port with zero padding, and is instantiated twice.
- Top: pointers, full flags, handshake, err, output mux.

Test Plan:
- Reset, then write slices 0..63 with element value = address (slice 63 with wr_last) -> wr_ready stays 1 until that edge; rd_bank_ready=1 next cycle; wb=1.
- rd_en rd_addr=10 -> next cycle rd_valid=1, lanes {10,11,12,13}.
  - rd_addr=574 (DEPTH=576) -> lanes {574,575,0,0}.
- Fill bank 1 with values +1000 while reading bank 0, then fill again -> wr_ready=0 after both full.
  - rd_release -> rb=1, reads return 1000+addr, wr_ready returns to 1.
- rd_en before any fill -> rd_valid=0, err=1.
  - rd_release with no full bank -> err stays 1, pointers unchanged.
- Same-cycle rd_en rd_addr=0 and rd_release -> returns bank 0 element 0; following read returns the bank 1 value.
- Assert rst mid-layer after 20 slices -> wr_ready=1, rd_bank_ready=0, err=0. Refill works normally.
